// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between the control core (port 0) and the audio path (port 1):
// round-robin req/gnt front end, registered operand stage, per-port result capture with done pulse.
module alu_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       op0,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic [5:0]       flags0,
  output logic [5:0]       flags1,
  output logic             busy,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alucont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_l,
  input  logic             alu_f,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_zero,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL1 = 2'd2,
    MUL2 = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             own_q, own_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [3:0]       cont_q, cont_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [5:0]       flags0_q, flags0_d;
  logic [5:0]       flags1_q, flags1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  logic             grant_ok;
  logic             gnt0_c, gnt1_c;
  logic             any_gnt;
  logic             win;
  logic [3:0]       win_op;
  logic [WIDTH-1:0] win_a, win_b;
  logic             capture;
  logic [5:0]       alu_flags;

  // Handshake: a requester holds req with stable op/operands; gnt is combinational in the
  // same cycle and the request is consumed at that clock edge. No grant in MUL1 or in reset.
  always_comb begin
    grant_ok = (state_q != MUL1) && !reset;
    gnt0_c   = grant_ok && req0 && (!req1 || last_q);
    gnt1_c   = grant_ok && req1 && (!req0 || !last_q);
    any_gnt  = gnt0_c || gnt1_c;
    win      = gnt1_c;
    win_op   = win ? op1 : op0;
    win_a    = win ? a1 : a0;
    win_b    = win ? b1 : b0;
  end

  always_comb begin
    capture   = (state_q == EXEC) || (state_q == MUL2);
    alu_flags = {alu_c, alu_l, alu_f, alu_z, alu_n, alu_zero};
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    cont_d   = cont_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    flags0_d = flags0_q;
    flags1_d = flags1_q;
    done0_d  = capture && !own_q;
    done1_d  = capture && own_q;

    if (capture && !own_q) begin
      res0_d   = alu_result;
      flags0_d = alu_flags;
    end
    if (capture && own_q) begin
      res1_d   = alu_result;
      flags1_d = alu_flags;
    end

    // A grant always restarts the pipe; otherwise MUL1 advances and everything else drains to IDLE.
    if (any_gnt) begin
      in1_d   = win_a;
      in2_d   = win_b;
      cont_d  = win_op;
      own_d   = win;
      last_d  = win;
      state_d = (win_op[2:0] == 3'b111) ? MUL1 : EXEC;
    end else if (state_q == MUL1) begin
      state_d = MUL2;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      cont_q   <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
      flags0_q <= '0;
      flags1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      cont_q   <= cont_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
      flags0_q <= flags0_d;
      flags1_q <= flags1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign flags0    = flags0_q;
  assign flags1    = flags1_q;
  assign busy      = (state_q != IDLE);
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alucont   = cont_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed + randomized bench for alu_share_ctrl with a behavioural ALU attached and a
// per-port scoreboard of expected {done cycle, flags, result}.
module tb_alu_share_ctrl;
  localparam int W   = 16;
  localparam int SBW = 32 + 6 + W;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1010;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [3:0]   op0, op1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] res0, res1;
  logic [5:0]   flags0, flags1;
  logic         busy;
  logic [W-1:0] alu_in1, alu_in2;
  logic [3:0]   alucont;
  logic [W-1:0] alu_result;
  logic         alu_c, alu_l, alu_f, alu_z, alu_n, alu_zero;
  logic [1:0]   state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_w   = 1;
  int mul_cyc  = -10;
  logic [SBW-1:0] exp_q0[$];
  logic [SBW-1:0] exp_q1[$];
  logic [W-1:0]   hold_r0 = '0, hold_r1 = '0;
  logic [5:0]     hold_f0 = '0, hold_f1 = '0;
  logic [3:0]     ops [6] = '{4'b0010, 4'b1010, 4'b0111, 4'b0000, 4'b0110, 4'b1111};

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1), .flags0(flags0), .flags1(flags1),
    .busy(busy), .alu_in1(alu_in1), .alu_in2(alu_in2), .alucont(alucont),
    .alu_result(alu_result), .alu_c(alu_c), .alu_l(alu_l), .alu_f(alu_f),
    .alu_z(alu_z), .alu_n(alu_n), .alu_zero(alu_zero), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  function automatic logic [W-1:0] mul_lo(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return p[W-1:0];
  endfunction

  // Reference ALU: returns {C,L,F,Z,N,zero, result}
  function automatic logic [6+W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic [5:0]   f;
    f = '0;
    r = '0;
    if (op[2:0] == 3'b111) begin
      r = mul_lo(x, y);
    end else if (op == OP_ADD) begin
      s    = {1'b0, x} + {1'b0, y};
      r    = s[W-1:0];
      f[5] = s[W];
    end else if (op == OP_CMP) begin
      r    = (x >= y) ? (x - y) : (y - x);
      f[5] = (x >= y);
      f[4] = (x < y);
      f[2] = (x == y);
      f[1] = (x < y);
    end else if (op == 4'b0110) begin
      r = x & y;
    end else begin
      r = x ^ y;
    end
    f[0] = (r == '0);
    return {f, r};
  endfunction

  // Attached ALU: multiply result appears one cycle after the operands settle.
  logic [W-1:0]   prod_q = '0;
  logic [6+W-1:0] alu_out;
  always @(posedge clk) prod_q <= mul_lo(alu_in1, alu_in2);
  always_comb begin
    alu_out = alu_model(alucont, alu_in1, alu_in2);
    if (alucont[2:0] == 3'b111) alu_out = {5'b0, (prod_q == '0), prod_q};
  end
  assign {alu_c, alu_l, alu_f, alu_z, alu_n, alu_zero, alu_result} = alu_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    logic [6+W-1:0] m;
    int lat;
    m   = alu_model(op, a, b);
    lat = (op[2:0] == 3'b111) ? 3 : 2;
    if (p == 0) exp_q0.push_back({32'(cyc + lat), m});
    else        exp_q1.push_back({32'(cyc + lat), m});
    last_w = p;
    if (op[2:0] == 3'b111) mul_cyc = cyc;
  endtask

  task automatic pop_check(input int p, input logic [W-1:0] r, input logic [5:0] f);
    logic [SBW-1:0] e;
    int n;
    n = (p == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("done%0d_pending", p), 64'(n != 0), 64'd1);
    if (n != 0) begin
      if (p == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("done%0d_cycle", p), 64'(cyc), 64'(e[SBW-1 -: 32]));
      check($sformatf("res%0d", p), 64'(r), 64'(e[W-1:0]));
      check($sformatf("flags%0d", p), 64'(f), 64'(e[W+5:W]));
    end
  endtask

  // Scoreboard monitor: each done pops one expectation; between dones results must hold.
  always @(negedge clk) begin
    if (reset) begin
      hold_r0 = '0; hold_r1 = '0; hold_f0 = '0; hold_f1 = '0;
    end else begin
      if (done0) begin
        pop_check(0, res0, flags0);
        hold_r0 = res0; hold_f0 = flags0;
      end else begin
        check("res0_hold", {flags0, res0}, {hold_f0, hold_r0});
      end
      if (done1) begin
        pop_check(1, res1, flags1);
        hold_r1 = res1; hold_f1 = flags1;
      end else begin
        check("res1_hold", {flags1, res1}, {hold_f1, hold_r1});
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input string tag, input int p, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int   waited;
    logic g;
    waited = 0;
    g      = 1'b0;
    if (p == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    while (!g && waited < 8) begin
      @(negedge clk);
      g = (p == 0) ? gnt0 : gnt1;
      if (!g) begin
        waited++;
        @(posedge clk); #1;
      end
    end
    check({tag, "_gnt_wait"}, 64'(waited), 64'd0);
    check({tag, "_other_gnt"}, 64'((p == 0) ? gnt1 : gnt0), 64'd0);
    if (g) push_exp(p, op, a, b);
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;

    // reset state, with requests pending that must not be granted
    repeat (2) @(posedge clk);
    #1;
    req0 = 1'b1; req1 = 1'b1; op0 = OP_ADD; op1 = OP_ADD;
    @(negedge clk);
    check("rst_results", {res0, res1, flags0, flags1}, '0);
    check("rst_ctrl", {done0, done1, gnt0, gnt1, busy, alucont, state_dbg}, '0);
    check("rst_operands", {alu_in1, alu_in2}, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // tie right after reset: 0,1,0,1 on consecutive cycles
    a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("tie_gnt_%0d", i), {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (gnt0) push_exp(0, op0, a0, b0);
      if (gnt1) push_exp(1, op1, a1, b1);
      @(posedge clk); #1;
      if (i % 2 == 0) begin a0 = rnd(); b0 = rnd(); end
      else            begin a1 = rnd(); b1 = rnd(); end
    end
    req0 = 1'b0; req1 = 1'b0;
    drain();

    // single op
    issue("single", 0, OP_ADD, 16'h0003, 16'h0004);
    drain();
    check("single_res0", 64'(res0), 64'h0007);

    // compare, equal operands
    issue("cmp_eq", 0, OP_CMP, 16'h0005, 16'h0005);
    drain();
    check("cmp_res0", 64'(res0), 64'h0000);
    check("cmp_flags0", 64'(flags0), 64'b100101);

    // multiply on port 1 with port 0 pending (last winner is port 0)
    req1 = 1'b1; op1 = OP_MUL; a1 = 16'h0010; b1 = 16'h0020;
    req0 = 1'b1; op0 = OP_ADD; a0 = rnd(); b0 = rnd();
    @(negedge clk);
    check("mul_c0_gnt", {gnt1, gnt0}, 2'b10);
    if (gnt1) push_exp(1, op1, a1, b1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    check("mul_c1_gnt", {gnt1, gnt0}, 2'b00);
    check("mul_c1_state", {busy, state_dbg}, 3'b110);
    @(posedge clk); #1;
    @(negedge clk);
    check("mul_c2_gnt", {gnt1, gnt0}, 2'b01);
    if (gnt0) push_exp(0, op0, a0, b0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("mul_c3_done1", 64'(done1), 64'd1);
    check("mul_res1", 64'(res1), 64'h0200);
    @(posedge clk); #1;
    drain();

    // subtract ordering
    issue("sub", 0, OP_CMP, 16'h0003, 16'h000A);
    drain();
    check("sub_res0", 64'(res0), 64'h0007);
    check("sub_n0", 64'(flags0[1]), 64'd1);

    // random traffic, arbitration checked against the round-robin rule
    for (int k = 0; k < 120; k++) begin
      logic [1:0] eg;
      logic g0, g1;
      if (!req0 && $urandom_range(0, 3) != 0) begin
        req0 = 1'b1; op0 = ops[$urandom_range(0, 5)]; a0 = rnd(); b0 = rnd();
      end else if (req0 && $urandom_range(0, 15) == 0) begin
        req0 = 1'b0;
      end
      if (!req1 && $urandom_range(0, 3) != 0) begin
        req1 = 1'b1; op1 = ops[$urandom_range(0, 5)]; a1 = rnd(); b1 = rnd();
      end else if (req1 && $urandom_range(0, 15) == 0) begin
        req1 = 1'b0;
      end
      @(negedge clk);
      if (mul_cyc == cyc - 1)  eg = 2'b00;
      else if (req0 && req1)   eg = (last_w == 1) ? 2'b01 : 2'b10;
      else                     eg = {req1, req0};
      check("rand_gnt", {gnt1, gnt0}, eg);
      g0 = gnt0;
      g1 = gnt1;
      if (g0) push_exp(0, op0, a0, b0);
      if (g1) push_exp(1, op1, a1, b1);
      @(posedge clk); #1;
      if (g0) req0 = 1'b0;
      if (g1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    drain();

    // reset in MUL1: op discarded, no done, arbitration back to port 0 first
    req0 = 1'b1; op0 = OP_MUL; a0 = 16'h0123; b0 = 16'h0045;
    @(negedge clk);
    check("rstmul_gnt0", 64'(gnt0), 64'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b1; op1 = OP_ADD; a1 = rnd(); b1 = rnd();
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    last_w  = 1;
    mul_cyc = -10;
    @(negedge clk);
    check("rstmul_no_gnt", {gnt1, gnt0}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("rstmul_results", {res0, res1, flags0, flags1}, '0);
    check("rstmul_ctrl", {done0, done1, busy, alucont, state_dbg}, '0);
    check("rstmul_operands", {alu_in1, alu_in2}, '0);
    repeat (4) @(posedge clk);
    #1;
    req0 = 1'b1; req1 = 1'b1; op0 = OP_ADD; op1 = OP_ADD;
    a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd();
    @(negedge clk);
    check("rstmul_tie", {gnt1, gnt0}, 2'b01);
    if (gnt0) push_exp(0, op0, a0, b0);
    if (gnt1) push_exp(1, op1, a1, b1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    drain();

    check("final_queues", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbiter and sequencer that shares one `alu` instance between two requesters, the control core (port 0) and the audio processing path (port 1). It accepts operations over a req/gnt handshake with round-robin fairness and drives the ALU from a registered operand stage. It captures result and flags per requester and returns them with a one-cycle `done` pulse. Multiply ops get a two-cycle execute window; all other ops issue back-to-back at one per cycle.

## Interface
- `WIDTH`, 16, datapath width; must match the attached `alu`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `req0` / `req1`  in  1  request; held high with stable op/operands until granted
- `op0` / `op1`  in  4  ALU control code, passed unchanged to `alucont`
- `a0` / `a1`  in  WIDTH  operand routed to `alu_in1`
- `b0` / `b1`  in  WIDTH  operand routed to `alu_in2`
- `gnt0` / `gnt1`  out  1  combinational accept; request consumed at this clock edge
- `done0` / `done1`  out  1  one-cycle pulse; `res`/`flags` for that port are valid
- `res0` / `res1`  out  WIDTH  registered result, held until that port's next `done`
- `flags0` / `flags1`  out  6  registered {C,L,F,Z,N,zero}, updated with `res`
- `busy`  out  1  high while any op is in EXEC/MUL1/MUL2
- `alu_in1`, `alu_in2`  out  WIDTH  registered operands to ALU
- `alucont`  out  4  registered control to ALU
- `alu_result`  in  WIDTH  ALU result
- `alu_c`, `alu_l`, `alu_f`, `alu_z`, `alu_n`, `alu_zero`  in  1  ALU flags

## Operation
- States: IDLE, EXEC, MUL1, MUL2. Operand stage: `alu_in1`, `alu_in2`, `alucont`, owner tag `own`. Round-robin pointer `last` is the port granted most recently.
- A grant is possible when the state is IDLE, EXEC or MUL2, and never in MUL1 or while `reset` is high.
- Arbitration:
  - One request only: that port wins.
  - Both requesting: the port != `last` wins.
  - `last` resets to 1, so port 0 wins the first tie.
  - At most one `gnt` is high per cycle.
- On a grant edge:
  - Load the operand stage from the winner and set `own`.
  - Update `last`.
  - Next state is MUL1 if `op[2:0]==3'b111`, else EXEC.
- EXEC:
  - At the end of the cycle, capture `alu_result` and flags into `res/flags[own]`.
  - Pulse `done[own]` in the next cycle.
  - Next state is decided by that edge's grant: EXEC or MUL1 if granted, else IDLE.
- MUL1: operands held, no capture, next state is MUL2.
- MUL2: capture as in EXEC; the next state follows the same grant rule as EXEC.
- Operand stage holds its value when no grant occurs.
- The unselected port's `res`/`flags` are untouched.
- Width rules:
  - `res` equals the low WIDTH bits of `alu_result`.
  - The multiply product is truncated by the ALU.
  - The block does no arithmetic itself.

## Timing
- Reset values:
  - All outputs are 0: `res*`, `flags*`, `done*`, `gnt*`, `busy`, `alu_in1`, `alu_in2`, `alucont`.
  - State is IDLE, `last`=1, `own`=0.
- Latency, counted from the grant edge (cycle 0):
  - Non-multiply: `done` is high in cycle 2.
  - Multiply: `done` is high in cycle 3.
- Throughput:
  - Non-multiply: one op per cycle.
  - A multiply blocks grants for exactly one cycle (MUL1).
- Requesters sample `gnt` in the same cycle they drive `req`. After a grant, the next op may be presented in the following cycle.
- A `done` pulse and a new grant to the same port may coincide. `res` updates on the done edge regardless.
- Reset asserted mid-operation:
  - The in-flight op is discarded and no `done` is issued.
  - Results go to 0, and pending requests must be re-held after reset deasserts.
- `req` dropped before grant: the op is silently withdrawn. This is legal.

## Test plan
- Single op:
  - Stimulus: after reset, `req0`, `op0`=4'b0010, `a0`=0x0003, `b0`=0x0004.
  - Response: `gnt0` in cycle 0, `done0` in cycle 2, `res0`=0x0007, `done1` stays 0.
- Tie after reset:
  - Stimulus: `req0` and `req1` both held, ADD ops.
  - Response: grants alternate 0,1,0,1 in consecutive cycles; `done` pulses alternate two cycles later.
- Multiply:
  - Stimulus: `req1`, `op1`=4'b0111, `a1`=0x0010, `b1`=0x0020, with `req0` also pending.
  - Response: `gnt1` at cycle 0, no grant at cycle 1, `gnt0` at cycle 2, `done1` at cycle 3 with `res1`=0x0200.
- Compare flags:
  - Stimulus: `op0`=4'b1010, `a0`=`b0`=0x0005.
  - Response: `res0`=0x0000, `flags0`=6'b100101.
- Subtract ordering:
  - Stimulus: `op0`=4'b1010, `a0`=0x0003, `b0`=0x000A.
  - Response: `res0`=0x0007, `flags0[1]` (N)=1.
- Reset during multiply:
  - Stimulus: grant a multiply, then assert `reset` in MUL1.
  - Response: no `done`, all outputs 0, state IDLE, next tie goes to port 0.
